// File: rtl/seg_to_bcd_reader_if.sv
// Token channel of the 7-segment read-back monitor: decoded digit, dp and
// error flag qualified by a ready/valid handshake.
interface seg_to_bcd_reader_if;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_digit;
    logic       out_dp;
    logic       out_err;

    modport master (
        output out_valid,
        output out_digit,
        output out_dp,
        output out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_digit,
        input  out_dp,
        input  out_err,
        output out_ready
    );
endinterface

// File: rtl/seg_to_bcd_reader.sv
// Debounces an 8-bit 7-segment drive pattern, decodes it back to BCD and emits one
// ready/valid token per newly stable pattern; illegal patterns are flagged and counted.
module seg_to_bcd_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            seg_in,
    input  logic                  sample_en,
    seg_to_bcd_reader_if.master   out_bus,
    output logic [ERR_CNT_W-1:0]  err_count
);

    typedef enum logic {
        TRACK = 1'b0,
        OUT   = 1'b1
    } state_t;

    typedef struct packed {
        logic       blank;
        logic       err;
        logic [3:0] digit;
    } dec_t;

    localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);
    // Accept fires on the STABLE_CYCLES-th identical sample, when cnt still lags by two.
    localparam logic [7:0] C_ACCEPT = 8'(STABLE_CYCLES - 2);

    function automatic dec_t decode(input logic [6:0] pat);
        dec_t d;
        d.blank = 1'b0;
        d.err   = 1'b0;
        d.digit = 4'h0;
        case (pat)
            7'h3F: d.digit = 4'd0;
            7'h06: d.digit = 4'd1;
            7'h5B: d.digit = 4'd2;
            7'h4F: d.digit = 4'd3;
            7'h66: d.digit = 4'd4;
            7'h6D: d.digit = 4'd5;
            7'h7D: d.digit = 4'd6;
            7'h27: d.digit = 4'd7;
            7'h7F: d.digit = 4'd8;
            7'h67: d.digit = 4'd9;
            7'h00: d.blank = 1'b1;
            default: begin
                d.err   = 1'b1;
                d.digit = 4'hF;
            end
        endcase
        return d;
    endfunction

    state_t               r_state;
    logic [7:0]           r_seg_q;
    logic [7:0]           r_cnt;
    logic [6:0]           r_last_pat;
    logic                 r_out_valid;
    logic [3:0]           r_out_digit;
    logic                 r_out_dp;
    logic                 r_out_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    state_t               w_state_next;
    logic [7:0]           w_seg_q_next;
    logic [7:0]           w_cnt_next;
    logic [6:0]           w_last_pat_next;
    logic                 w_out_valid_next;
    logic [3:0]           w_out_digit_next;
    logic                 w_out_dp_next;
    logic                 w_out_err_next;
    logic [ERR_CNT_W-1:0] w_err_count_next;
    dec_t                 w_dec;
    logic                 w_same;
    logic                 w_accept;

    assign w_dec    = decode(seg_in[6:0]);
    assign w_same   = (seg_in == r_seg_q);
    assign w_accept = (r_state == TRACK) && sample_en && w_same && (r_cnt == C_ACCEPT);

    always_comb begin
        // NOTE: every target gets its hold value first so no path can infer a latch.
        w_state_next     = r_state;
        w_seg_q_next     = r_seg_q;
        w_cnt_next       = r_cnt;
        w_last_pat_next  = r_last_pat;
        w_out_valid_next = r_out_valid;
        w_out_digit_next = r_out_digit;
        w_out_dp_next    = r_out_dp;
        w_out_err_next   = r_out_err;
        w_err_count_next = r_err_count;

        case (r_state)
            TRACK: begin
                if (sample_en) begin
                    w_seg_q_next = seg_in;
                    if (!w_same) begin
                        w_cnt_next = 8'd0;
                    end else if (r_cnt >= C_STABLE) begin
                        w_cnt_next = C_STABLE;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end

                // A repeat of the last reported pattern (dp ignored) stays silent;
                // a blank only re-arms so the next digit is reported again.
                if (w_accept && (seg_in[6:0] != r_last_pat)) begin
                    if (w_dec.blank) begin
                        w_last_pat_next = 7'h00;
                    end else begin
                        w_last_pat_next  = seg_in[6:0];
                        w_out_digit_next = w_dec.digit;
                        w_out_dp_next    = seg_in[7];
                        w_out_err_next   = w_dec.err;
                        w_out_valid_next = 1'b1;
                        w_cnt_next       = 8'd0;
                        w_state_next     = OUT;
                        if (w_dec.err && (r_err_count != '1)) begin
                            w_err_count_next = r_err_count + ERR_CNT_W'(1);
                        end
                    end
                end
            end

            OUT: begin
                w_cnt_next = 8'd0;
                // Handover restarts tracking with the current sample as run start.
                if (out_bus.out_ready) begin
                    w_out_valid_next = 1'b0;
                    w_seg_q_next     = seg_in;
                    w_state_next     = TRACK;
                end
            end

            default: begin
                w_state_next = TRACK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= TRACK;
            r_seg_q     <= 8'h00;
            r_cnt       <= 8'd0;
            r_last_pat  <= 7'h00;
            r_out_valid <= 1'b0;
            r_out_digit <= 4'h0;
            r_out_dp    <= 1'b0;
            r_out_err   <= 1'b0;
            r_err_count <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values.
            r_state     <= w_state_next;
            r_seg_q     <= w_seg_q_next;
            r_cnt       <= w_cnt_next;
            r_last_pat  <= w_last_pat_next;
            r_out_valid <= w_out_valid_next;
            r_out_digit <= w_out_digit_next;
            r_out_dp    <= w_out_dp_next;
            r_out_err   <= w_out_err_next;
            r_err_count <= w_err_count_next;
        end
    end

    assign out_bus.out_valid = r_out_valid;
    assign out_bus.out_digit = r_out_digit;
    assign out_bus.out_dp    = r_out_dp;
    assign out_bus.out_err   = r_out_err;
    assign err_count         = r_err_count;

endmodule
